// File: rtl/stopwatch_pkg.sv
// ----------------------------------------------------------------------------
// Module   : stopwatch_pkg
// Desc     : Shared types and constants for the stopwatch button front end:
//            per-channel state encoding, button indices, default timing for a
//            1 kHz clk_fast and a counter-width helper.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package stopwatch_pkg;

  // Per-channel button state
  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PRESS_WAIT   = 3'd1,
    ST_HELD         = 3'd2,
    ST_REPEAT       = 3'd3,
    ST_RELEASE_WAIT = 3'd4
  } btn_state_e;

  // Button index assignments on the stopwatch board
  localparam int BTN_RST   = 0;
  localparam int BTN_PAUSE = 1;
  localparam int BTN_ADJ   = 2;
  localparam int BTN_SEL   = 3;

  // Default timing for a 1 kHz clk_fast (1 ms per cycle)
  localparam int DEF_NUM_BTN       = 4;
  localparam int DEF_DEB_CYCLES    = 8;    // 8 ms debounce
  localparam int DEF_HOLD_CYCLES   = 500;  // 0.5 s before first repeat
  localparam int DEF_REPEAT_CYCLES = 250;  // 4 repeats per second

  // Counter width wide enough for the largest terminal count, plus one bit
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_event_gen_if.sv
// ----------------------------------------------------------------------------
// Module   : button_event_gen_if
// Desc     : Bundle of raw button inputs and the per-button event outputs.
//            master = board/consumer side, slave = button_event_gen.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface button_event_gen_if
  import stopwatch_pkg::*;
#(
  parameter int NUM_BTN = DEF_NUM_BTN
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [NUM_BTN-1:0] btn_repeat;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_repeat
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_repeat
  );

endinterface

`default_nettype wire

// File: rtl/btn_channel.sv
// ----------------------------------------------------------------------------
// Module   : btn_channel
// Desc     : One button channel: 2-flop synchronizer, debounce/hold FSM and
//            registered level/press/release/repeat outputs.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module btn_channel
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter bit REPEAT_EN     = 1'b0
) (
  input  logic clk_fast,
  input  logic rst,
  input  logic btn_raw_i,
  output logic btn_level_o,
  output logic btn_press_o,
  output logic btn_release_o,
  output logic btn_repeat_o
);

  localparam int            CW        = cnt_width(DEB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [1:0]    sync_q;
  logic          w_s;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] deb_q, deb_d;
  logic [CW-1:0] hold_q, hold_d;
  logic          was_rep_q, was_rep_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          repeat_q, repeat_d;

  // Two-flop synchronizer on the asynchronous pin
  always_ff @(posedge clk_fast) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], btn_raw_i};
  end

  assign w_s = sync_q[1];

  // State, counters and registered event outputs
  always_ff @(posedge clk_fast) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      deb_q     <= '0;
      hold_q    <= '0;
      was_rep_q <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_q     <= deb_d;
      hold_q    <= hold_d;
      was_rep_q <= was_rep_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  // Next-state, counter updates and event decode. A single-sample debounce
  // (DEB_LAST == 0) accepts directly from IDLE/HELD/REPEAT.
  always_comb begin
    state_d   = state_q;
    deb_d     = deb_q;
    hold_d    = hold_q;
    was_rep_d = was_rep_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        deb_d     = '0;
        hold_d    = '0;
        was_rep_d = 1'b0;
        if (w_s) begin
          if (DEB_LAST == '0) begin
            state_d = ST_HELD;
            press_d = 1'b1;
          end else begin
            state_d = ST_PRESS_WAIT;
            deb_d   = CNT_ONE;
          end
        end
      end

      ST_PRESS_WAIT: begin
        if (!w_s) begin
          state_d = ST_IDLE;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = ST_HELD;
          press_d = 1'b1;
          deb_d   = '0;
          hold_d  = '0;
        end else begin
          deb_d = deb_q + CNT_ONE;
        end
      end

      ST_HELD: begin
        if (!w_s) begin
          was_rep_d = 1'b0;
          if (DEB_LAST == '0) begin
            state_d   = ST_IDLE;
            release_d = 1'b1;
            hold_d    = '0;
          end else begin
            state_d = ST_RELEASE_WAIT;
            deb_d   = CNT_ONE;
          end
        end else if (REPEAT_EN && (hold_q == HOLD_LAST)) begin
          state_d  = ST_REPEAT;
          repeat_d = 1'b1;
          hold_d   = '0;
        end else if (hold_q != HOLD_LAST) begin
          // saturates on non-repeating channels so the counter never wraps
          hold_d = hold_q + CNT_ONE;
        end
      end

      ST_REPEAT: begin
        if (!w_s) begin
          was_rep_d = 1'b1;
          if (DEB_LAST == '0) begin
            state_d   = ST_IDLE;
            release_d = 1'b1;
            hold_d    = '0;
          end else begin
            state_d = ST_RELEASE_WAIT;
            deb_d   = CNT_ONE;
          end
        end else if (hold_q == REP_LAST) begin
          repeat_d = 1'b1;
          hold_d   = '0;
        end else begin
          hold_d = hold_q + CNT_ONE;
        end
      end

      ST_RELEASE_WAIT: begin
        // hold_q is left untouched so the repeat cadence resumes on a bounce
        if (w_s) begin
          state_d = was_rep_q ? ST_REPEAT : ST_HELD;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          deb_d     = '0;
          hold_d    = '0;
          was_rep_d = 1'b0;
        end else begin
          deb_d = deb_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        deb_d   = '0;
        hold_d  = '0;
      end
    endcase

    level_d = (state_d == ST_HELD) || (state_d == ST_REPEAT) ||
              (state_d == ST_RELEASE_WAIT);
  end

  assign btn_level_o   = level_q;
  assign btn_press_o   = press_q;
  assign btn_release_o = release_q;
  assign btn_repeat_o  = repeat_q;

endmodule

`default_nettype wire

// File: rtl/button_event_gen.sv
// ----------------------------------------------------------------------------
// Module   : button_event_gen
// Desc     : Multi-channel button front end. Produces debounced level, press,
//            release and auto-repeat events per button on clk_fast.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module button_event_gen
  import stopwatch_pkg::*;
#(
  parameter int                 NUM_BTN       = DEF_NUM_BTN,
  parameter int                 DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int                 HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int                 REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK   = '0
) (
  input  logic                clk_fast,
  input  logic                rst,
  button_event_gen_if.slave   btn_if
);

  logic [NUM_BTN-1:0] w_level;
  logic [NUM_BTN-1:0] w_press;
  logic [NUM_BTN-1:0] w_release;
  logic [NUM_BTN-1:0] w_repeat;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
    btn_channel #(
      .DEB_CYCLES    (DEB_CYCLES),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .REPEAT_EN     (REPEAT_MASK[gi])
    ) u_chan (
      .clk_fast      (clk_fast),
      .rst           (rst),
      .btn_raw_i     (btn_if.btn_raw[gi]),
      .btn_level_o   (w_level[gi]),
      .btn_press_o   (w_press[gi]),
      .btn_release_o (w_release[gi]),
      .btn_repeat_o  (w_repeat[gi])
    );
  end

  assign btn_if.btn_level   = w_level;
  assign btn_if.btn_press   = w_press;
  assign btn_if.btn_release = w_release;
  assign btn_if.btn_repeat  = w_repeat;

endmodule

`default_nettype wire

// File: tb/tb_button_event_gen.sv
// ----------------------------------------------------------------------------
// Module   : tb_button_event_gen
// Desc     : Self-checking bench for button_event_gen with short timing
//            (DEB=4, HOLD=10, REPEAT=5, mask 4'b0010). Cycle 0 of each
//            scenario is the cycle in which btn_raw changes.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_button_event_gen;

  localparam int NB = 4;
  localparam int SIG_LEVEL = 0, SIG_PRESS = 1, SIG_RELEASE = 2, SIG_REPEAT = 3;

  typedef struct {
    int   first;
    int   last;
    int   sig;
    int   ch;
    logic exp;
  } exp_t;

  logic clk_fast = 1'b0;
  logic rst      = 1'b1;

  button_event_gen_if #(.NUM_BTN(NB)) u_if ();

  button_event_gen #(
    .NUM_BTN       (NB),
    .DEB_CYCLES    (4),
    .HOLD_CYCLES   (10),
    .REPEAT_CYCLES (5),
    .REPEAT_MASK   (4'b0010)
  ) dut (
    .clk_fast (clk_fast),
    .rst      (rst),
    .btn_if   (u_if.slave)
  );

  always #5 clk_fast = ~clk_fast;

  int errors = 0;
  int checks = 0;

  logic [NB-1:0] raw_sched [0:127];
  logic          rst_sched [0:127];
  logic [NB-1:0] lv [0:127];
  logic [NB-1:0] pr [0:127];
  logic [NB-1:0] rl [0:127];
  logic [NB-1:0] rp [0:127];
  exp_t          tbl [$];

  function automatic string sig_name(input int sig);
    case (sig)
      SIG_LEVEL:   return "level";
      SIG_PRESS:   return "press";
      SIG_RELEASE: return "release";
      default:     return "repeat";
    endcase
  endfunction

  function automatic logic get_bit(input int sig, input int c, input int ch);
    case (sig)
      SIG_LEVEL:   return lv[c][ch];
      SIG_PRESS:   return pr[c][ch];
      SIG_RELEASE: return rl[c][ch];
      default:     return rp[c][ch];
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic clear_sched();
    for (int k = 0; k < 128; k++) begin
      raw_sched[k] = '0;
      rst_sched[k] = 1'b0;
    end
    tbl.delete();
  endtask

  task automatic set_raw(input int ch, input int first, input int last, input logic v);
    for (int k = first; k <= last; k++) raw_sched[k][ch] = v;
  endtask

  task automatic add_row(input int first, input int last, input int sig, input int ch, input logic exp);
    exp_t r;
    if (first > last) return;
    r.first = first; r.last = last; r.sig = sig; r.ch = ch; r.exp = exp;
    tbl.push_back(r);
  endtask

  // Pulses at start + j*period (j < count), zero elsewhere in [first,last]
  task automatic add_train(input int sig, input int ch, input int first, input int last,
                           input int start, input int period, input int count);
    int c;
    c = first;
    for (int j = 0; j < count; j++) begin
      int p;
      p = start + j * period;
      add_row(c, p - 1, sig, ch, 1'b0);
      add_row(p, p, sig, ch, 1'b1);
      c = p + 1;
    end
    add_row(c, last, sig, ch, 1'b0);
  endtask

  task automatic add_quiet(input int ch, input int first, input int last);
    for (int s = 0; s < 4; s++) add_row(first, last, s, ch, 1'b0);
  endtask

  task automatic do_reset();
    u_if.btn_raw = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk_fast);
    #1;
    rst = 1'b0;
  endtask

  // Record outputs during cycle k, then drive the inputs for cycle k
  task automatic run_scn(input int len);
    for (int k = 0; k < len; k++) begin
      @(posedge clk_fast);
      #1;
      lv[k] = u_if.btn_level;
      pr[k] = u_if.btn_press;
      rl[k] = u_if.btn_release;
      rp[k] = u_if.btn_repeat;
      u_if.btn_raw = raw_sched[k];
      rst          = rst_sched[k];
    end
    u_if.btn_raw = '0;
    rst = 1'b0;
  endtask

  task automatic check_table(input string scn);
    for (int i = 0; i < tbl.size(); i++) begin
      checks++;
      for (int c = tbl[i].first; c <= tbl[i].last; c++) begin
        if (get_bit(tbl[i].sig, c, tbl[i].ch) !== tbl[i].exp) begin
          errors++;
          $display("FAIL %s row%0d %s[%0d] cycle %0d: got %0b, expected %0b",
                   scn, i, sig_name(tbl[i].sig), tbl[i].ch, c,
                   get_bit(tbl[i].sig, c, tbl[i].ch), tbl[i].exp);
          break;
        end
      end
    end
  endtask

  initial begin
    int n, first, last, gapbad;
    u_if.btn_raw = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk_fast);
    #1;
    check("reset level",   32'(u_if.btn_level),   32'd0);
    check("reset press",   32'(u_if.btn_press),   32'd0);
    check("reset release", 32'(u_if.btn_release), 32'd0);
    check("reset repeat",  32'(u_if.btn_repeat),  32'd0);
    rst = 1'b0;

    // Clean press on ch1 with auto-repeat
    clear_sched();
    set_raw(1, 0, 29, 1'b1);
    add_train(SIG_PRESS, 1, 0, 49, 6, 1, 1);
    add_row(0, 5, SIG_LEVEL, 1, 1'b0);
    add_row(6, 35, SIG_LEVEL, 1, 1'b1);
    add_row(36, 49, SIG_LEVEL, 1, 1'b0);
    add_train(SIG_REPEAT, 1, 0, 49, 16, 5, 4);
    add_train(SIG_RELEASE, 1, 0, 49, 36, 1, 1);
    add_quiet(0, 0, 49); add_quiet(2, 0, 49); add_quiet(3, 0, 49);
    do_reset(); run_scn(50); check_table("clean_ch1");

    // Bounce on ch0: no event until the restarted debounce completes
    clear_sched();
    set_raw(0, 0, 2, 1'b1);
    set_raw(0, 4, 40, 1'b1);
    add_train(SIG_PRESS, 0, 0, 49, 10, 1, 1);
    add_row(0, 9, SIG_LEVEL, 0, 1'b0);
    add_row(10, 46, SIG_LEVEL, 0, 1'b1);
    add_train(SIG_REPEAT, 0, 0, 49, 0, 1, 0);
    add_train(SIG_RELEASE, 0, 0, 49, 47, 1, 1);
    add_quiet(1, 0, 49); add_quiet(2, 0, 49); add_quiet(3, 0, 49);
    do_reset(); run_scn(50); check_table("bounce_ch0");

    // Glitch on ch2 is discarded
    clear_sched();
    set_raw(2, 0, 2, 1'b1);
    for (int ch = 0; ch < NB; ch++) add_quiet(ch, 0, 29);
    do_reset(); run_scn(30); check_table("glitch_ch2");

    // Release bounce on ch1 after repeating started
    clear_sched();
    set_raw(1, 0, 29, 1'b1);
    set_raw(1, 32, 59, 1'b1);
    add_train(SIG_PRESS, 1, 0, 79, 6, 1, 1);
    add_row(0, 5, SIG_LEVEL, 1, 1'b0);
    add_row(6, 65, SIG_LEVEL, 1, 1'b1);
    add_row(66, 79, SIG_LEVEL, 1, 1'b0);
    add_train(SIG_REPEAT, 1, 0, 36, 16, 5, 4);
    add_row(62, 79, SIG_REPEAT, 1, 1'b0);
    add_train(SIG_RELEASE, 1, 0, 79, 66, 1, 1);
    add_quiet(0, 0, 79); add_quiet(2, 0, 79); add_quiet(3, 0, 79);
    do_reset(); run_scn(80); check_table("relbounce_ch1");
    n = 0; first = -1; last = -1; gapbad = 0;
    for (int c = 37; c <= 61; c++) begin
      if (rp[c][1]) begin
        if (last >= 0 && (c - last) != 5) gapbad = 1;
        if (first < 0) first = c;
        last = c;
        n++;
      end
    end
    check("relbounce repeat count", 32'(n), 32'd5);
    check("relbounce first resumed repeat in 38..39", 32'(first >= 38 && first <= 39), 32'd1);
    check("relbounce repeat spacing ok", 32'(gapbad), 32'd0);

    // Reset while ch3 is held
    clear_sched();
    set_raw(3, 0, 39, 1'b1);
    rst_sched[12] = 1'b1;
    add_train(SIG_PRESS, 3, 0, 12, 6, 1, 1);
    add_train(SIG_PRESS, 3, 13, 39, 19, 1, 1);
    add_row(0, 5, SIG_LEVEL, 3, 1'b0);
    add_row(6, 12, SIG_LEVEL, 3, 1'b1);
    add_row(13, 18, SIG_LEVEL, 3, 1'b0);
    add_row(19, 39, SIG_LEVEL, 3, 1'b1);
    add_train(SIG_RELEASE, 3, 0, 39, 0, 1, 0);
    add_train(SIG_REPEAT, 3, 0, 39, 0, 1, 0);
    add_quiet(0, 0, 39); add_quiet(1, 0, 39); add_quiet(2, 0, 39);
    do_reset(); run_scn(40); check_table("rst_hold_ch3");

    // Simultaneous press on ch0 and ch3
    clear_sched();
    set_raw(0, 0, 29, 1'b1);
    set_raw(3, 0, 29, 1'b1);
    for (int i = 0; i < 2; i++) begin
      int ch;
      ch = (i == 0) ? 0 : 3;
      add_train(SIG_PRESS, ch, 0, 39, 6, 1, 1);
      add_row(0, 5, SIG_LEVEL, ch, 1'b0);
      add_row(6, 35, SIG_LEVEL, ch, 1'b1);
      add_row(36, 39, SIG_LEVEL, ch, 1'b0);
      add_train(SIG_RELEASE, ch, 0, 39, 36, 1, 1);
      add_train(SIG_REPEAT, ch, 0, 39, 0, 1, 0);
    end
    add_quiet(1, 0, 39); add_quiet(2, 0, 39);
    do_reset(); run_scn(40); check_table("simul_ch0_ch3");
    check("simul press vector at 6", 32'(pr[6]), 32'h9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
- Multi-channel button front end for the stopwatch. Turns raw asynchronous push-button inputs into clean per-button events on clk_fast for the control logic:
  - a debounced level
  - a one-cycle press pulse
  - a one-cycle release pulse
  - an auto-repeat pulse while the button is held
- Sits between the board pins and the top-level control (reset, pause, adjust-select). Replaces the per-button debouncer instances and the edge detection now done in the consumer.

Parameters:
NUM_BTN, 4, number of independent button channels
DEB_CYCLES, 8, consecutive stable synchronized samples required to accept a press or a release
HOLD_CYCLES, 500, cycles after the press pulse before the first repeat pulse
REPEAT_CYCLES, 250, cycles between subsequent repeat pulses
REPEAT_MASK, 4'b0000, per-channel enable for auto-repeat; bit i=1 enables channel i

Ports:
clk_fast  in  1  block clock; all state on rising edge
rst  in  1  synchronous, active-high reset
btn_raw  in  NUM_BTN  raw asynchronous button inputs, active-high
btn_level  out  NUM_BTN  debounced button state
btn_press  out  NUM_BTN  one-cycle pulse on accepted press
btn_release  out  NUM_BTN  one-cycle pulse on accepted release
btn_repeat  out  NUM_BTN  one-cycle auto-repeat pulse while held

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk_fast. No other clock or reset.
- Reset values: all outputs 0; synchronizer flops 0; every channel in IDLE; all counters 0.
- Synchronizer: two flops per bit. The synchronized sample s[i] lags btn_raw[i] by 2 cycles.
- Channels are fully independent. Simultaneous events on different channels all assert in the same cycle.
- Per-channel FSM states:
  - IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT.
  - deb_cnt, hold_cnt and the was_repeat flag are per channel.
- IDLE:
  - btn_level=0.
  - s=1 -> PRESS_WAIT with deb_cnt=1.
- PRESS_WAIT:
  - s=0 -> IDLE. No event; a glitch is discarded.
  - s=1 and deb_cnt==DEB_CYCLES-1 -> HELD, with btn_press=1 for that one cycle, btn_level=1 and hold_cnt=0.
  - Otherwise deb_cnt++.
- Press latency: a clean rise on btn_raw produces btn_press exactly 2+DEB_CYCLES cycles later.
- HELD:
  - hold_cnt++ each cycle.
  - If REPEAT_MASK[i]=1 and hold_cnt reaches HOLD_CYCLES: pulse btn_repeat, clear hold_cnt, go to REPEAT.
  - s=0 -> RELEASE_WAIT with deb_cnt=1 and was_repeat=0.
- REPEAT:
  - hold_cnt++ each cycle.
  - hold_cnt reaches REPEAT_CYCLES -> btn_repeat pulse and hold_cnt cleared.
  - s=0 -> RELEASE_WAIT with was_repeat=1.
- RELEASE_WAIT:
  - btn_level stays 1 and hold_cnt is frozen.
  - s=1 -> return to REPEAT if was_repeat=1, else HELD. hold_cnt resumes from its frozen value.
  - s=0 and deb_cnt==DEB_CYCLES-1 -> IDLE, with btn_release=1 for one cycle and btn_level=0.
  - Otherwise deb_cnt++.
- Release latency: 2+DEB_CYCLES cycles after a clean fall.
- Pulse exclusivity: btn_press, btn_repeat and btn_release are mutually exclusive per channel in any cycle.
  - btn_repeat pulses only while btn_level=1.
  - Channels with REPEAT_MASK[i]=0 never leave HELD for REPEAT.
- Counter widths: $clog2 of the largest of DEB_CYCLES, HOLD_CYCLES and REPEAT_CYCLES, plus 1. Counters never wrap, because each is cleared on reaching its terminal value.
- Reset mid-operation:
  - All channels return to IDLE immediately; outputs are 0 the next cycle.
  - No release pulse is generated.
  - A button held through reset is re-accepted as a new press 2+DEB_CYCLES cycles after rst deasserts.
- Degenerate parameter: DEB_CYCLES=1 is legal. Acceptance happens on the first stable sample.

Decomposition:
- Shared package stopwatch_pkg:
  - per-channel state encoding: IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT
  - button index constants: BTN_RST=0, BTN_PAUSE=1, BTN_ADJ=2, BTN_SEL=3
  - default timing constants for a 1 kHz clk_fast
- One sub-module, btn_channel:
  - one synchronizer, FSM and counter set
  - instantiated NUM_BTN times by a generate loop
  - REPEAT_MASK[i] passed as a single-bit parameter

Test Plan:
- Bench parameters: DEB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=5, REPEAT_MASK=4'b0010. In each scenario, cycle 0 is the cycle in which btn_raw changes.
- Clean press on ch1: btn_raw[1] high cycles 0-29 -> btn_press[1] at 6; btn_level[1] high 6-35; btn_repeat[1] at 16, 21, 26, 31; btn_release[1] at 36. No activity on other channels.
- Bounce on ch0: btn_raw[0] high 0-2, low 3, high 4-40 -> no event before 10; single btn_press[0] at 10; no btn_repeat (mask bit 0 is clear).
- Glitch on ch2: btn_raw[2] high 0-2 only -> btn_press, btn_level, btn_release and btn_repeat all stay 0 on ch2.
- Release bounce on ch1 after repeat started: low for 2 cycles, then high again -> no release; repeat cadence resumes from the frozen hold_cnt; single release after the final stable low.
- Reset mid-hold on ch3: btn_raw[3] held from 0; rst=1 at cycle 12 for 1 cycle -> all outputs 0 at 13; no btn_release; new btn_press[3] 6 cycles after rst deasserts.
- Simultaneous press on ch0 and ch3 at cycle 0 -> btn_press[0] and btn_press[3] both at 6, in the same cycle.
